ones_counter_pipe: RTL

//  Parametrised, pipelined population counter. Counts the 1s in an N-bit input vector.

---
 rtl/ones_counter_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ones_counter_pipe.sv
// Two-stage pipelined population counter with valid/ready flow control
// and an optional saturating running total. Define THRESH_EN for thresh/above.
module ones_counter_pipe #(
    parameter int N     = 15,
    parameter int CW    = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic [ACC_W-1:0] acc_total,
    output logic             acc_sat
`ifdef THRESH_EN
    ,
    input  logic [CW-1:0]    thresh,
    output logic             above
`endif
);

    localparam int NL = N / 2;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    logic             s1_v_q, s1_v_d;
    logic [CW-1:0]    s1_lo_q, s1_lo_d;
    logic [CW-1:0]    s1_hi_q, s1_hi_d;
    logic             s1_mode_q, s1_mode_d;
    logic             s2_v_q, s2_v_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s2_mode_q, s2_mode_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
`ifdef THRESH_EN
    logic [CW-1:0]    s1_thr_q, s1_thr_d;
    logic             above_q, above_d;
`endif

    logic             s1_adv, s2_adv, s1_acc, out_hs;
    logic [CW-1:0]    lo_cnt, hi_cnt, s1_sum;
    logic [ACC_W:0]   acc_sum;

    assign s2_adv    = !s2_v_q | out_ready;
    assign s1_adv    = !s1_v_q | s2_adv;
    assign s1_acc    = in_valid & s1_adv;
    assign out_hs    = s2_v_q & out_ready;
    assign s1_sum    = s1_lo_q + s1_hi_q;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v_q;
    assign out_count = cnt_q;
    assign acc_total = acc_q;
    assign acc_sat   = sat_q;
`ifdef THRESH_EN
    assign above     = above_q;
`endif

    // Half-vector popcounts; the high half gets the extra bit for odd N
    always_comb begin
        lo_cnt = '0;
        hi_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (i < NL) lo_cnt = lo_cnt + CW'(in_data[i]);
            else        hi_cnt = hi_cnt + CW'(in_data[i]);
        end
    end

    // S1 captures partial counts and per-vector mode on an input handshake
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_lo_d   = s1_lo_q;
        s1_hi_d   = s1_hi_q;
        s1_mode_d = s1_mode_q;
`ifdef THRESH_EN
        s1_thr_d  = s1_thr_q;
`endif
        if (s1_adv) s1_v_d = in_valid;
        if (s1_acc) begin
            s1_lo_d   = lo_cnt;
            s1_hi_d   = hi_cnt;
            s1_mode_d = mode;
`ifdef THRESH_EN
            s1_thr_d  = thresh;
`endif
        end
    end

    // S2 holds the final count; it only reloads when the output may advance
    always_comb begin
        s2_v_d    = s2_v_q;
        cnt_d     = cnt_q;
        s2_mode_d = s2_mode_q;
`ifdef THRESH_EN
        above_d   = above_q;
`endif
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                cnt_d     = s1_sum;
                s2_mode_d = s1_mode_q;
`ifdef THRESH_EN
                above_d   = (s1_sum >= s1_thr_q);
`endif
            end
        end
    end

    // Running total: clear wins over a same-cycle add; saturate at all-ones
    always_comb begin
        acc_d   = acc_q;
        sat_d   = sat_q;
        acc_sum = {1'b0, acc_q} + (ACC_W+1)'(cnt_q);
        if (acc_clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (out_hs && s2_mode_q) begin
            if (acc_sum >= {1'b0, ACC_MAX}) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    // State registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_lo_q   <= '0;
            s1_hi_q   <= '0;
            s1_mode_q <= 1'b0;
            s2_v_q    <= 1'b0;
            cnt_q     <= '0;
            s2_mode_q <= 1'b0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
`ifdef THRESH_EN
            s1_thr_q  <= '0;
            above_q   <= 1'b0;
`endif
        end else begin
            s1_v_q    <= s1_v_d;
            s1_lo_q   <= s1_lo_d;
            s1_hi_q   <= s1_hi_d;
            s1_mode_q <= s1_mode_d;
            s2_v_q    <= s2_v_d;
            cnt_q     <= cnt_d;
            s2_mode_q <= s2_mode_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
`ifdef THRESH_EN
            s1_thr_q  <= s1_thr_d;
            above_q   <= above_d;
`endif
        end
    end

endmodule
